// File: rtl/imem_load_fetch_ctrl.sv
// imem_load_fetch_ctrl: owns a single-port instruction memory.
// In LOAD it streams a program image from a valid/ready loader into memory
// from address 0, and in RUN it serves processor fetches with a fixed
// 1-cycle latency.
// Optional feature: define IMEM_FETCH_CHECK_EN to reject misaligned or
// out-of-range fetch addresses. A rejected fetch returns NOP_WORD with
// fetch_err set.
module imem_load_fetch_ctrl #(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    input  logic              fetch_req,
    input  logic [31:0]       pc,
    output logic              fetch_valid,
    output logic [31:0]       inst,
    output logic              fetch_err,
    output logic              stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              load_ovf,
    output logic [ADDR_W-2:0] words_loaded
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    // Address of the last word in memory; the load pointer never moves past it.
    localparam logic [ADDR_W-1:0] PTR_TOP = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              xfer;
    logic              at_top;
    logic              fetch_ok;
    logic              pc_bad;
    logic              valid_q;
    logic              err_q;

    // A restart in the same cycle takes precedence over a pending loader word.
    assign xfer     = (state == LOAD) && ld_valid && !ld_start;
    assign at_top   = (ptr == PTR_TOP);
    assign fetch_ok = (state == RUN) && fetch_req;

`ifdef IMEM_FETCH_CHECK_EN
    assign pc_bad = (pc[1:0] != 2'b00) || ((pc >> ADDR_W) != 32'd0);
`else
    assign pc_bad = 1'b0;
    logic unused_pc;
    assign unused_pc = ^{pc[31:ADDR_W], pc[1:0]};
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: ld_start always (re)enters LOAD
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ld_start) state_nxt = LOAD;
            LOAD: begin
                if (ld_start)                         state_nxt = LOAD;
                else if (xfer && (ld_last || at_top)) state_nxt = RUN;
            end
            RUN:  if (ld_start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: memory port ownership and handshake/stall per state
    always_comb begin
        ld_ready  = 1'b0;
        stall     = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            LOAD: begin
                ld_ready = 1'b1;
                if (xfer) begin
                    mem_we    = 1'b1;
                    mem_addr  = ptr;
                    mem_wdata = ld_data;
                end
            end
            RUN: begin
                stall = 1'b0;
                if (fetch_ok && !pc_bad) mem_addr = {pc[ADDR_W-1:2], 2'b00};
            end
            default: ;
        endcase
    end

    // Load pointer, word count, overflow flag and fetch-response pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            words_loaded <= '0;
            load_ovf     <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // A fetch accepted in the cycle of ld_start still gets its response.
            valid_q <= fetch_ok;
            err_q   <= fetch_ok && pc_bad;
            if (ld_start) begin
                ptr          <= '0;
                words_loaded <= '0;
                load_ovf     <= 1'b0;
            end else if (xfer) begin
                words_loaded <= words_loaded + (ADDR_W-1)'(1);
                if (!at_top)
                    ptr <= ptr + ADDR_W'(4);
                else if (!ld_last)
                    load_ovf <= 1'b1;
            end
        end
    end

    assign fetch_valid = valid_q;
    assign fetch_err   = err_q;
    assign inst        = valid_q ? (err_q ? NOP_WORD : mem_rdata) : '0;

endmodule
